// File: rtl/vga_pkg.sv
// Shared definitions for the VGA scanline prefetch stage:
// default geometry, FSM encoding and the blank word.
package vga_pkg;

   localparam int DEF_WORDS = 80;
   localparam int DEF_IDX_W = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   localparam logic [15:0] BLANK = 16'h0000;

endpackage

// File: rtl/line_ram.sv
// Ping-pong line buffer: 2*WORDS x 16, one sync write port and one
// sync read port that owns the display output register.
module line_ram
   import vga_pkg::*;
#(
   parameter int WORDS = DEF_WORDS,
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             we,
   input  logic             wbank,
   input  logic [IDX_W-1:0] widx,
   input  logic [15:0]      wdata,
   input  logic             rbank,
   input  logic [IDX_W-1:0] ridx,
   output logic [15:0]      rdata
);

   localparam int AW = $clog2(2 * WORDS);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);
   localparam logic [AW-1:0] BANK_OFS = AW'(WORDS);

   logic [15:0]   mem_q [2*WORDS];
   logic [AW-1:0] waddr;
   logic [AW-1:0] raddr;
   logic [15:0]   rdata_d;
   logic [15:0]   rdata_q;

   always_comb begin
      waddr = AW'(widx) + (wbank ? BANK_OFS : '0);
      raddr = AW'(ridx) + (rbank ? BANK_OFS : '0);
      rdata_d = BLANK;
      if (ridx <= LAST) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Array is never reset; only the output register is.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rdata_q <= BLANK;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/vga_line_fetch.sv
// Scanline prefetch: fills the next line into one bank while the
// display reads the other with fixed 1-cycle latency.
module vga_line_fetch
   import vga_pkg::*;
#(
   parameter int WORDS = DEF_WORDS,
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        line_start,
   input  logic [15:0] line_base,
   input  logic [15:0] vga_addr,
   output logic [15:0] vga_data,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_gnt,
   input  logic [15:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic        busy,
   output logic        underrun
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [15:0]      base_q, base_d;
   logic [15:0]      mem_addr_q, mem_addr_d;
   logic             disp_bank_q, disp_bank_d;
   logic             mem_req_q, mem_req_d;
   logic             busy_q, busy_d;
   logic             underrun_q, underrun_d;
   logic             accept;
   logic             wr_en;
   logic             unused_addr;

   assign unused_addr = ^vga_addr[15:IDX_W];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      base_d      = base_q;
      disp_bank_d = disp_bank_q;
      underrun_d  = 1'b0;
      accept      = 1'b0;
      wr_en       = 1'b0;
      unique case (state_q)
         IDLE: begin
            accept = line_start;
         end
         REQ: begin
            underrun_d = line_start;
            if (mem_gnt) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            underrun_d = line_start;
            if (mem_rvalid) begin
               wr_en = 1'b1;
               if (cnt_q == LAST) begin
                  // final word lands: a coincident line_start is on time
                  state_d    = IDLE;
                  accept     = line_start;
                  underrun_d = 1'b0;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = REQ;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (accept) begin
         disp_bank_d = ~disp_bank_q;
         base_d      = line_base;
         cnt_d       = '0;
         state_d     = REQ;
      end
      mem_req_d  = (state_d == REQ);
      busy_d     = (state_d != IDLE);
      mem_addr_d = base_d + 16'(cnt_d);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         base_q      <= '0;
         mem_addr_q  <= '0;
         disp_bank_q <= 1'b0;
         mem_req_q   <= 1'b0;
         busy_q      <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         base_q      <= base_d;
         mem_addr_q  <= mem_addr_d;
         disp_bank_q <= disp_bank_d;
         mem_req_q   <= mem_req_d;
         busy_q      <= busy_d;
         underrun_q  <= underrun_d;
      end
   end

   line_ram #(
      .WORDS (WORDS),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_en & reset_n),
      .wbank   (~disp_bank_q),
      .widx    (cnt_q),
      .wdata   (mem_rdata),
      .rbank   (disp_bank_q),
      .ridx    (vga_addr[IDX_W-1:0]),
      .rdata   (vga_data)
   );

   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign busy     = busy_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Scoreboard bench for vga_line_fetch: random memory timing and
// display reads checked against a line-level reference model.
module tb_vga_line_fetch;

   localparam int WORDS = 80;
   localparam int IDX_W = 7;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        line_start = 1'b0;
   logic [15:0] line_base = 16'h0;
   logic [15:0] vga_addr = 16'h0;
   logic [15:0] vga_data;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic [15:0] mem_rdata = 16'h0;
   logic        mem_rvalid = 1'b0;
   logic        busy;
   logic        underrun;

   vga_line_fetch #(.WORDS(WORDS), .IDX_W(IDX_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .line_start (line_start),
      .line_base  (line_base),
      .vga_addr   (vga_addr),
      .vga_data   (vga_data),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .busy       (busy),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model state (line granularity)
   logic [15:0] exp_addr[$];
   bit          m_fetch = 0;
   bit          have_fill = 0;
   bit          disp_valid = 0;
   int          m_words = 0;
   logic [15:0] fill_base = 16'h0;
   logic [15:0] disp_base = 16'h0;

   function automatic logic [15:0] mem_word(logic [15:0] a);
      return a ^ 16'hA5A5;
   endfunction

   // Stimulus controls, written only by the main process
   int          gnt_mode = 1;
   int          lat_min = 1;
   int          lat_max = 1;
   int          ls_tok = 0;
   int          ls_mode = 0;
   logic [15:0] ls_base = 16'h0;

   // Written only by the driver
   int          ls_done = 0;
   bit          pend = 0;
   int          pend_lat = 0;
   logic [15:0] pend_addr = 16'h0;
   logic [IDX_W-1:0] sweep = '0;

   // Memory / arbiter and line_start driver, all on the falling edge
   always @(negedge clk) begin
      line_start = 1'b0;
      mem_rvalid = 1'b0;
      if (pend) begin
         pend_lat--;
         if (pend_lat == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(pend_addr);
            pend       = 0;
         end
      end
      case (gnt_mode)
         0:       mem_gnt = 1'b0;
         1:       mem_gnt = 1'b1;
         default: mem_gnt = 1'($urandom_range(1, 0));
      endcase
      if (mem_req === 1'b1 && mem_gnt) begin
         n_chk++;
         if (pend || exp_addr.size() == 0) begin
            n_fail++;
            $display("FAIL mem_req_unexpected: addr %h pend %0d queued %0d",
                     mem_addr, pend, exp_addr.size());
         end else begin
            chk("mem_addr", mem_addr, exp_addr.pop_front());
         end
         pend      = 1;
         pend_lat  = $urandom_range(lat_max, lat_min);
         pend_addr = mem_addr;
      end
      if (ls_tok != ls_done &&
          (ls_mode == 0 ||
           (mem_rvalid && m_fetch && m_words == WORDS - 1))) begin
         line_start = 1'b1;
         line_base  = ls_base;
         ls_done    = ls_tok;
      end
      vga_addr = {9'($urandom), sweep};
      sweep    = sweep + 1'b1;
   end

   // Reference model + monitor
   always begin : monitor
      logic [IDX_W-1:0] idx;
      logic [15:0]      rd_exp;
      bit               rd_ok;
      bit               rv, last, acc, under;
      @(posedge clk);
      if (!reset_n) begin
         m_fetch    = 0;
         have_fill  = 0;
         disp_valid = 0;
         m_words    = 0;
         exp_addr.delete();
         #2;
         chk("rst_vga_data", vga_data, 16'h0);
         chk("rst_mem_req", 16'(mem_req), 16'h0);
         chk("rst_mem_addr", mem_addr, 16'h0);
         chk("rst_busy", 16'(busy), 16'h0);
         chk("rst_underrun", 16'(underrun), 16'h0);
      end else begin
         idx    = vga_addr[IDX_W-1:0];
         rd_ok  = (int'(idx) >= WORDS) || disp_valid;
         rd_exp = (int'(idx) >= WORDS) ? 16'h0 :
                  mem_word(disp_base + 16'(idx));
         rv    = mem_rvalid && m_fetch;
         last  = rv && (m_words == WORDS - 1);
         if (rv) m_words++;
         acc   = line_start && (!m_fetch || last);
         under = line_start && !acc;
         if (last) m_fetch = 0;
         if (acc) begin
            disp_valid = have_fill;
            disp_base  = fill_base;
            have_fill  = 1;
            fill_base  = line_base;
            m_fetch    = 1;
            m_words    = 0;
            for (int i = 0; i < WORDS; i++) begin
               exp_addr.push_back(line_base + 16'(i));
            end
         end
         #2;
         if (rd_ok) chk("vga_data", vga_data, rd_exp);
         chk("underrun", 16'(underrun), 16'(under));
         chk("busy", 16'(busy), 16'(m_fetch));
      end
   end

   task automatic fire(logic [15:0] base, int mode);
      int n;
      n       = 0;
      ls_base = base;
      ls_mode = mode;
      ls_tok++;
      while (ls_done != ls_tok && n < 5000) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (ls_done != ls_tok) begin
         n_fail++;
         $display("FAIL line_start_timeout: base %h not issued", base);
         ls_done = ls_tok;
      end
      ls_mode = 0;
      @(negedge clk);
   endtask

   task automatic wait_idle(int bound, output int cyc);
      cyc = 0;
      while (m_fetch && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
      n_chk++;
      if (m_fetch) begin
         n_fail++;
         $display("FAIL fetch_timeout: words %0d after %0d cycles",
                  m_words, cyc);
      end
   endtask

   initial begin
      int cyc;
      int n;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Normal fill, immediate grant, minimum latency
      fire(16'h1000, 0);
      wait_idle(2000, cyc);
      n_chk++;
      if (cyc < 150 || cyc > 3 * WORDS) begin
         n_fail++;
         $display("FAIL fill_cycles: got %0d expected 150..%0d",
                  cyc, 3 * WORDS);
      end

      // Address wrap with random grant and latency
      gnt_mode = 2;
      lat_max  = 3;
      fire(16'hFFF0, 0);
      wait_idle(5000, cyc);

      // Coincident line_start with the final rvalid
      fire(16'h3000, 0);
      fire(16'h4000, 2);
      repeat (2) @(negedge clk);
      wait_idle(5000, cyc);

      // Underrun: starve the grant, then pulse line_start
      gnt_mode = 0;
      fire(16'h5000, 0);
      repeat (300) @(negedge clk);
      fire(16'h6000, 0);
      #1;
      chk("underrun_mem_req", 16'(mem_req), 16'h1);
      chk("underrun_mem_addr", mem_addr, 16'h5000);
      gnt_mode = 2;
      wait_idle(5000, cyc);
      fire(16'h7000, 0);

      // Reset while word 40 is outstanding
      gnt_mode = 1;
      lat_min  = 3;
      lat_max  = 3;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(mem_req && mem_gnt && m_words == 40) && n < 2000);
      n_chk++;
      if (n >= 2000) begin
         n_fail++;
         $display("FAIL reset_point_timeout: words %0d", m_words);
      end
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);

      gnt_mode = 2;
      lat_min  = 1;
      lat_max  = 2;
      fire(16'h8000, 0);
      wait_idle(5000, cyc);
      fire(16'h9000, 0);
      wait_idle(5000, cyc);
      repeat (150) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
